ysyx_22040750_ex_mem_stage: RTL

Parametrised EX->MEM pipeline stage with valid/allowin handshake. It holds one instruction's sideband payload, issues at most one load or store request per instruction on a ready/valid memory channel, and waits for the response. It registers the load data so the output stays stable while the stage is stalled. Compared with the previous fixed-field register, it adds a generic payload width, a response data register, flush with in-flight drain, and store-ack tracking.

---
 rtl/ysyx_22040750_pkg.sv | 17 +
 rtl/ysyx_22040750_ex_mem_stage.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ysyx_22040750_pkg.sv
// Shared types for the EX->MEM stage: state encoding and
// default memory bus widths.
package ysyx_22040750_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_DRAIN = 3'd5
  } ex_mem_state_e;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

endpackage

// File: rtl/ysyx_22040750_ex_mem_stage.sv
// EX->MEM stage: holds one instruction, issues at most one
// memory request for it and registers the load data.
module ysyx_22040750_ex_mem_stage
  import ysyx_22040750_pkg::*;
#(
  parameter int PAYLOAD_W = 256,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic                 I_sys_clk,
  input  logic                 I_rst,
  input  logic                 I_flush,
  input  logic                 I_valid,
  output logic                 O_allowin,
  input  logic [PAYLOAD_W-1:0] I_payload,
  input  logic                 I_is_load,
  input  logic                 I_is_store,
  input  logic [ADDR_W-1:0]    I_addr,
  input  logic [DATA_W-1:0]    I_wdata,
  input  logic [STRB_W-1:0]    I_wstrb,
  output logic                 O_req_valid,
  input  logic                 I_req_ready,
  output logic                 O_req_we,
  output logic [ADDR_W-1:0]    O_req_addr,
  output logic [DATA_W-1:0]    O_req_wdata,
  output logic [STRB_W-1:0]    O_req_wstrb,
  input  logic                 I_resp_valid,
  input  logic [DATA_W-1:0]    I_resp_data,
  output logic                 O_valid,
  input  logic                 I_allowout,
  output logic [PAYLOAD_W-1:0] O_payload,
  output logic [ADDR_W-1:0]    O_addr,
  output logic [DATA_W-1:0]    O_rdata,
  output logic                 O_busy
);

  ex_mem_state_e state_q, state_d;

  logic [PAYLOAD_W-1:0] payload_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [STRB_W-1:0]    wstrb_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 we_q;

  logic accept;
  logic is_mem;
  logic hs;
  logic cap_rdata;

  assign O_valid   = (state_q == S_HOLD) || (state_q == S_DONE);
  assign O_allowin = !I_flush &&
                     ((state_q == S_IDLE) || (O_valid && I_allowout));
  assign accept    = I_valid && O_allowin;
  assign is_mem    = I_is_load || I_is_store;
  assign hs        = (state_q == S_REQ) && I_req_ready;
  assign cap_rdata = (state_q == S_WAIT) && I_resp_valid &&
                     !I_flush && !we_q;

  always_comb begin
    state_d = state_q;
    if (I_flush) begin
      unique case (state_q)
        S_REQ:   state_d = hs ? S_DRAIN : S_IDLE;
        S_WAIT,
        S_DRAIN: state_d = I_resp_valid ? S_IDLE : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE, S_HOLD, S_DONE: begin
          if (accept)
            state_d = is_mem ? S_REQ : S_HOLD;
          else if (state_q != S_IDLE && I_allowout)
            state_d = S_IDLE;
        end
        S_REQ:   if (hs) state_d = S_WAIT;
        S_WAIT:  if (I_resp_valid) state_d = S_DONE;
        S_DRAIN: if (I_resp_valid) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q   <= S_IDLE;
      payload_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        payload_q <= I_payload;
        addr_q    <= I_addr;
        wdata_q   <= I_wdata;
        wstrb_q   <= I_wstrb;
        // load wins when both flags are set
        we_q      <= I_is_store && !I_is_load;
      end
      if (cap_rdata)
        rdata_q <= I_resp_data;
    end
  end

  assign O_req_valid = (state_q == S_REQ);
  assign O_req_we    = we_q;
  assign O_req_addr  = addr_q;
  assign O_req_wdata = wdata_q;
  assign O_req_wstrb = wstrb_q;
  assign O_payload   = payload_q;
  assign O_addr      = addr_q;
  assign O_rdata     = rdata_q;
  assign O_busy      = (state_q != S_IDLE);

endmodule
